// File: rtl/pl_exception_sequencer.sv
// Exception entry/return sequencer for the 5-stage pipeline.
// Picks one exception source, latches EPC/cause and raises EXL. It then
// stalls and flushes the pipeline for a fixed window and finally issues a
// one-cycle redirect to the handler vector. ERET redirects back to EPC.
//
// state      | meaning
// -----------+------------------------------------------------------
// S_IDLE     | waiting for a request or ERET; all pipeline controls low
// S_FLUSH    | stall + bubble insertion for FLUSH_CYCLES cycles
// S_REDIRECT | one-cycle redirect to the handler vector
// S_ERET_RDR | one-cycle redirect to EPC; EXL clears when leaving
module pl_exception_sequencer #(
  parameter logic [31:0] UNDEF_VECTOR = 32'h0000_0100,
  parameter logic [31:0] OVF_VECTOR   = 32'h0000_0180,
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0200,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        id_undefined,
  input  logic [31:0] id_pc,
  input  logic        ex_overflow,
  input  logic [31:0] ex_pc,
  input  logic        irq,
  input  logic        eret,
  output logic        stall,
  output logic [2:0]  flush_mask,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        exl,
  output logic        dropped
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2,
    S_ERET_RDR = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic [2:0]    mask_q;

  logic          req_any;
  logic          take;
  logic          do_eret;
  logic          drop_d;
  logic [31:0]   epc_sel;
  logic [1:0]    cause_sel;
  logic [2:0]    mask_sel;
  logic [31:0]   vector;

  // Request arbitration: the oldest instruction (EX) wins over ID and irq.
  always_comb begin
    epc_sel   = id_pc;
    cause_sel = 2'b11;
    mask_sel  = 3'b011;
    if (ex_overflow) begin
      epc_sel   = ex_pc;
      cause_sel = 2'b10;
      mask_sel  = 3'b111;
    end else if (id_undefined) begin
      cause_sel = 2'b01;
    end
  end

  assign req_any = ex_overflow | id_undefined | irq;
  assign take    = (state == S_IDLE) && enable && !exl && req_any;
  assign do_eret = (state == S_IDLE) && enable && exl && eret;
  // A sampled request that cannot be served is reported and discarded;
  // this also covers ERET winning over a request in the same cycle.
  assign drop_d  = enable && req_any && (exl || (state != S_IDLE));

  // Handler address for the latched cause.
  always_comb begin
    vector = 32'h0;
    case (cause)
      2'b01:   vector = UNDEF_VECTOR;
      2'b10:   vector = OVF_VECTOR;
      2'b11:   vector = IRQ_VECTOR;
      default: vector = 32'h0;
    endcase
  end

  // State, window counter and the exception registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      mask_q  <= 3'b000;
      epc     <= 32'h0;
      cause   <= 2'b00;
      exl     <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_nx;
      dropped <= drop_d;
      if (take) begin
        count  <= '0;
        epc    <= epc_sel;
        cause  <= cause_sel;
        mask_q <= mask_sel;
        exl    <= 1'b1;
      end else if (state == S_FLUSH) begin
        count <= count + CW'(1);
      end
      if (state == S_ERET_RDR) exl <= 1'b0;
    end
  end

  // Next state and pipeline control outputs.
  always_comb begin
    state_nx    = state;
    stall       = 1'b0;
    flush_mask  = 3'b000;
    pc_redirect = 1'b0;
    redirect_pc = 32'h0;
    case (state)
      S_IDLE: begin
        if (do_eret)   state_nx = S_ERET_RDR;
        else if (take) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        stall      = 1'b1;
        flush_mask = mask_q;
        if (count == COUNT_LAST) state_nx = S_REDIRECT;
      end
      S_REDIRECT: begin
        pc_redirect = 1'b1;
        redirect_pc = vector;
        state_nx    = S_IDLE;
      end
      S_ERET_RDR: begin
        pc_redirect = 1'b1;
        redirect_pc = epc;
        flush_mask  = 3'b001;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pl_exception_sequencer.sv
// Bench for pl_exception_sequencer: a directed vector table, hand-written
// reset and short-window sequences, then random traffic against a model.
// Two instances share all inputs: FLUSH_CYCLES=2 (index 0) and 1 (index 1).
module tb_pl_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        id_undefined = 1'b0;
  logic [31:0] id_pc = 32'h0;
  logic        ex_overflow = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic        irq = 1'b0;
  logic        eret = 1'b0;

  logic        stall_o    [2];
  logic [2:0]  mask_o     [2];
  logic        redir_o    [2];
  logic [31:0] rpc_o      [2];
  logic [31:0] epc_o      [2];
  logic [1:0]  cause_o    [2];
  logic        exl_o      [2];
  logic        drop_o     [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pl_exception_sequencer #(.FLUSH_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .id_undefined(id_undefined), .id_pc(id_pc),
    .ex_overflow(ex_overflow), .ex_pc(ex_pc),
    .irq(irq), .eret(eret),
    .stall(stall_o[0]), .flush_mask(mask_o[0]),
    .pc_redirect(redir_o[0]), .redirect_pc(rpc_o[0]),
    .epc(epc_o[0]), .cause(cause_o[0]), .exl(exl_o[0]), .dropped(drop_o[0])
  );

  pl_exception_sequencer #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .id_undefined(id_undefined), .id_pc(id_pc),
    .ex_overflow(ex_overflow), .ex_pc(ex_pc),
    .irq(irq), .eret(eret),
    .stall(stall_o[1]), .flush_mask(mask_o[1]),
    .pc_redirect(redir_o[1]), .redirect_pc(rpc_o[1]),
    .epc(epc_o[1]), .cause(cause_o[1]), .exl(exl_o[1]), .dropped(drop_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flush cycles still to go, and which redirect (if any)
  // is due next: 0 none, 1 handler, 2 return-from-exception.
  int          m_left  [2];
  int          m_pend  [2];
  logic        m_exl   [2];
  logic [31:0] m_epc   [2];
  logic [1:0]  m_cause [2];
  logic [2:0]  m_fmask [2];
  logic        m_drop  [2];

  function automatic logic [31:0] handler(input logic [1:0] c);
    case (c)
      2'b01:   return 32'h100;
      2'b10:   return 32'h180;
      2'b11:   return 32'h200;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_pend[k] = 0; m_exl[k] = 1'b0; m_epc[k] = 32'h0;
      m_cause[k] = 2'b00; m_fmask[k] = 3'b000; m_drop[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic en, input logic ovf, input logic und,
                            input logic ir, input logic er,
                            input logic [31:0] xpc, input logic [31:0] ipc);
    for (int k = 0; k < 2; k++) begin
      int  fc;
      bit  idle;
      bit  req;
      fc   = (k == 0) ? 2 : 1;
      idle = (m_left[k] == 0) && (m_pend[k] == 0);
      req  = ovf || und || ir;
      m_drop[k] = en && req && (m_exl[k] || !idle);
      if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) m_pend[k] = 1;
      end else if (m_pend[k] == 1) begin
        m_pend[k] = 0;
      end else if (m_pend[k] == 2) begin
        m_pend[k] = 0;
        m_exl[k]  = 1'b0;
      end else if (en) begin
        if (m_exl[k] && er) begin
          m_pend[k] = 2;
        end else if (!m_exl[k] && req) begin
          m_exl[k]  = 1'b1;
          m_left[k] = fc;
          if (ovf) begin
            m_epc[k] = xpc; m_cause[k] = 2'b10; m_fmask[k] = 3'b111;
          end else if (und) begin
            m_epc[k] = ipc; m_cause[k] = 2'b01; m_fmask[k] = 3'b011;
          end else begin
            m_epc[k] = ipc; m_cause[k] = 2'b11; m_fmask[k] = 3'b011;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < 2; k++) begin
      logic        e_stall;
      logic [2:0]  e_mask;
      logic        e_redir;
      logic [31:0] e_rpc;
      e_stall = (m_left[k] > 0);
      e_mask  = (m_left[k] > 0) ? m_fmask[k] : ((m_pend[k] == 2) ? 3'b001 : 3'b000);
      e_redir = (m_left[k] == 0) && (m_pend[k] != 0);
      e_rpc   = !e_redir ? 32'h0 : ((m_pend[k] == 1) ? handler(m_cause[k]) : m_epc[k]);
      chk($sformatf("m%0d stall", k), 32'(stall_o[k]), 32'(e_stall));
      chk($sformatf("m%0d flush_mask", k), 32'(mask_o[k]), 32'(e_mask));
      chk($sformatf("m%0d pc_redirect", k), 32'(redir_o[k]), 32'(e_redir));
      chk($sformatf("m%0d redirect_pc", k), rpc_o[k], e_rpc);
      chk($sformatf("m%0d epc", k), epc_o[k], m_epc[k]);
      chk($sformatf("m%0d cause", k), 32'(cause_o[k]), 32'(m_cause[k]));
      chk($sformatf("m%0d exl", k), 32'(exl_o[k]), 32'(m_exl[k]));
      chk($sformatf("m%0d dropped", k), 32'(drop_o[k]), 32'(m_drop[k]));
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic cyc(input logic en, input logic ovf, input logic und,
                     input logic ir, input logic er,
                     input logic [31:0] xpc, input logic [31:0] ipc);
    enable = en; ex_overflow = ovf; id_undefined = und; irq = ir; eret = er;
    ex_pc = xpc; id_pc = ipc;
    @(posedge clk);
    model_step(en, ovf, und, ir, er, xpc, ipc);
    #1;
    compare_model();
  endtask

  task automatic idle_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic async_reset_pulse();
    enable = 1'b0; ex_overflow = 1'b0; id_undefined = 1'b0; irq = 1'b0; eret = 1'b0;
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d stall", k), 32'(stall_o[k]), 32'h0);
      chk($sformatf("rst%0d flush_mask", k), 32'(mask_o[k]), 32'h0);
      chk($sformatf("rst%0d pc_redirect", k), 32'(redir_o[k]), 32'h0);
      chk($sformatf("rst%0d redirect_pc", k), rpc_o[k], 32'h0);
      chk($sformatf("rst%0d epc", k), epc_o[k], 32'h0);
      chk($sformatf("rst%0d cause", k), 32'(cause_o[k]), 32'h0);
      chk($sformatf("rst%0d exl", k), 32'(exl_o[k]), 32'h0);
      chk($sformatf("rst%0d dropped", k), 32'(drop_o[k]), 32'h0);
    end
    model_reset();
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic        en, ovf, und, ir, er;
    logic [31:0] xpc, ipc;
    logic        stall;
    logic [2:0]  mask;
    logic        redir;
    logic [31:0] rpc, epc;
    logic [1:0]  cause;
    logic        exl, drop;
  } vec_t;

  vec_t tbl [21];

  initial begin
    // en ovf und irq eret | ex_pc id_pc | stall mask redir rpc epc cause exl drop
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 32'h40,32'h0,  1'b1,3'b111,1'b0,32'h0,  32'h40,2'b10,1'b1,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b1,3'b111,1'b0,32'h0,  32'h40,2'b10,1'b1,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b0,3'b000,1'b1,32'h180,32'h40,2'b10,1'b1,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b0,3'b000,1'b0,32'h0,  32'h40,2'b10,1'b1,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h0, 32'h4,  1'b0,3'b000,1'b0,32'h0,  32'h40,2'b10,1'b1,1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,  1'b0,3'b001,1'b1,32'h40, 32'h40,2'b10,1'b1,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b0,3'b000,1'b0,32'h0,  32'h40,2'b10,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,  1'b0,3'b000,1'b0,32'h0,  32'h40,2'b10,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0, 32'h8,  1'b0,3'b000,1'b0,32'h0,  32'h40,2'b10,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 32'h20,32'h24, 1'b1,3'b111,1'b0,32'h0,  32'h20,2'b10,1'b1,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h0, 32'h28, 1'b1,3'b111,1'b0,32'h0,  32'h20,2'b10,1'b1,1'b1};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b0,3'b000,1'b1,32'h180,32'h20,2'b10,1'b1,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b0,3'b000,1'b0,32'h0,  32'h20,2'b10,1'b1,1'b0};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 32'h0, 32'h2c, 1'b0,3'b001,1'b1,32'h20, 32'h20,2'b10,1'b1,1'b1};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b0,3'b000,1'b0,32'h0,  32'h20,2'b10,1'b0,1'b0};
    tbl[15] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 32'h99,32'h10, 1'b1,3'b011,1'b0,32'h0,  32'h10,2'b01,1'b1,1'b0};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b1,3'b011,1'b0,32'h0,  32'h10,2'b01,1'b1,1'b0};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b0,3'b000,1'b1,32'h100,32'h10,2'b01,1'b1,1'b0};
    tbl[18] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h0, 32'h14, 1'b0,3'b000,1'b0,32'h0,  32'h10,2'b01,1'b1,1'b1};
    tbl[19] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0,  1'b0,3'b001,1'b1,32'h10, 32'h10,2'b01,1'b1,1'b0};
    tbl[20] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0,  1'b0,3'b000,1'b0,32'h0,  32'h10,2'b01,1'b0,1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", 32'(stall_o[0]), 32'h0);
    chk("reset epc", epc_o[0], 32'h0);
    chk("reset exl", 32'(exl_o[0]), 32'h0);
    #4 reset = 1'b0;

    // Directed vector table, checked against fixed expectations.
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].en, tbl[i].ovf, tbl[i].und, tbl[i].ir, tbl[i].er, tbl[i].xpc, tbl[i].ipc);
      chk($sformatf("tbl%0d stall", i), 32'(stall_o[0]), 32'(tbl[i].stall));
      chk($sformatf("tbl%0d flush_mask", i), 32'(mask_o[0]), 32'(tbl[i].mask));
      chk($sformatf("tbl%0d pc_redirect", i), 32'(redir_o[0]), 32'(tbl[i].redir));
      chk($sformatf("tbl%0d redirect_pc", i), rpc_o[0], tbl[i].rpc);
      chk($sformatf("tbl%0d epc", i), epc_o[0], tbl[i].epc);
      chk($sformatf("tbl%0d cause", i), 32'(cause_o[0]), 32'(tbl[i].cause));
      chk($sformatf("tbl%0d exl", i), 32'(exl_o[0]), 32'(tbl[i].exl));
      chk($sformatf("tbl%0d dropped", i), 32'(drop_o[0]), 32'(tbl[i].drop));
    end

    // Reset in the middle of a flush window, then a fresh irq.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h30);
    chk("pre-reset in flush", 32'(stall_o[0]), 32'h1);
    async_reset_pulse();
    idle_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8);
    idle_cyc();
    idle_cyc();
    chk("irq redirect strobe", 32'(redir_o[0]), 32'h1);
    chk("irq redirect target", rpc_o[0], 32'h200);
    chk("irq epc", epc_o[0], 32'h8);
    idle_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    idle_cyc();

    // One-cycle window instance: mask only at T+1, redirect at T+2.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h50);
    chk("fc1 stall T+1", 32'(stall_o[1]), 32'h1);
    chk("fc1 mask T+1", 32'(mask_o[1]), 32'h3);
    idle_cyc();
    chk("fc1 stall T+2", 32'(stall_o[1]), 32'h0);
    chk("fc1 mask T+2", 32'(mask_o[1]), 32'h0);
    chk("fc1 redirect T+2", 32'(redir_o[1]), 32'h1);
    chk("fc1 target T+2", rpc_o[1], 32'h100);
    repeat (3) idle_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    idle_cyc();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset_pulse();
        idle_cyc();
      end else begin
        cyc(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 4) == 0),
            $urandom, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
